writeback_unit: RTL and testbench

Final pipeline stage: registers the MEM3 result, formats load data from the data cache by size/sign/byte-offset, and merges results from the multi-cycle multiplier. Drives the register-file write port consumed by the decode stage (WB_DATA / WB_DES / TYPE_MEM3_WB). Exactly one register write per cycle; x0 writes are never emitted.

---
 rtl/writeback_unit_pkg.sv | 29 ++
 rtl/writeback_unit_if.sv | 34 +++
 rtl/writeback_unit_load_formatter.sv | 41 ++++
 rtl/writeback_unit.sv | 89 ++++++++
 tb/tb_writeback_unit.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/writeback_unit_pkg.sv
// Shared pipeline parameters for the writeback stage: op-type constants,
// load size/sign codes and the multiplier hold-buffer record.
package writeback_unit_pkg;

  typedef enum logic [1:0] {
    TYPE_IDLE  = 2'b00,
    TYPE_ALU   = 2'b01,
    TYPE_LOAD  = 2'b10,
    TYPE_STORE = 2'b11
  } wb_type_e;

  localparam logic [2:0] FUN3_LB  = 3'b000;
  localparam logic [2:0] FUN3_LH  = 3'b001;
  localparam logic [2:0] FUN3_LW  = 3'b010;
  localparam logic [2:0] FUN3_LBU = 3'b100;
  localparam logic [2:0] FUN3_LHU = 3'b101;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
  } mul_hold_t;

  // Only alu and load entries produce a register write.
  function automatic logic writes_reg(input logic [1:0] op_type);
    return (op_type == TYPE_ALU) || (op_type == TYPE_LOAD);
  endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Bundle of the MEM3 entry, multiplier offer and register-file write port.
//
// Handshake: the multiplier offer (MUL_VALID, MUL_RD, MUL_DATA) is accepted on
// a rising edge where MUL_VALID & MUL_READY; while MUL_VALID is high and not
// accepted the producer holds MUL_RD/MUL_DATA stable. The MEM3 entry is
// consumed on any edge where DATA_CACHE_READY is high.
interface writeback_unit_if;
  logic [1:0]  TYPE_MEM3;
  logic [4:0]  RD_MEM3;
  logic [31:0] ALU_RESULT;
  logic [2:0]  FUN3_MEM3;
  logic [1:0]  ADDR_LO;
  logic [31:0] LOAD_DATA;
  logic        DATA_CACHE_READY;
  logic        MUL_VALID;
  logic [4:0]  MUL_RD;
  logic [31:0] MUL_DATA;
  logic        MUL_READY;
  logic [31:0] WB_DATA;
  logic [4:0]  WB_DES;
  logic [1:0]  TYPE_MEM3_WB;

  modport master (
    output TYPE_MEM3, RD_MEM3, ALU_RESULT, FUN3_MEM3, ADDR_LO, LOAD_DATA,
           DATA_CACHE_READY, MUL_VALID, MUL_RD, MUL_DATA,
    input  MUL_READY, WB_DATA, WB_DES, TYPE_MEM3_WB
  );

  modport slave (
    input  TYPE_MEM3, RD_MEM3, ALU_RESULT, FUN3_MEM3, ADDR_LO, LOAD_DATA,
           DATA_CACHE_READY, MUL_VALID, MUL_RD, MUL_DATA,
    output MUL_READY, WB_DATA, WB_DES, TYPE_MEM3_WB
  );
endinterface

// File: rtl/writeback_unit_load_formatter.sv
// Combinational load-data formatter: picks the byte/halfword addressed by
// ADDR_LO out of the aligned cache word and sign- or zero-extends it.
module load_formatter
  import writeback_unit_pkg::*;
(
  input  logic [2:0]  FUN3,
  input  logic [1:0]  ADDR_LO,
  input  logic [31:0] LOAD_DATA,
  output logic [31:0] FMT_DATA
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection; halfword uses only ADDR_LO[1].
  always_comb begin
    byte_sel = LOAD_DATA[7:0];
    case (ADDR_LO)
      2'd0: byte_sel = LOAD_DATA[7:0];
      2'd1: byte_sel = LOAD_DATA[15:8];
      2'd2: byte_sel = LOAD_DATA[23:16];
      2'd3: byte_sel = LOAD_DATA[31:24];
      default: byte_sel = LOAD_DATA[7:0];
    endcase
    half_sel = ADDR_LO[1] ? LOAD_DATA[31:16] : LOAD_DATA[15:0];
  end

  // Extension by size/sign code; unknown codes pass the whole word.
  always_comb begin
    FMT_DATA = LOAD_DATA;
    case (FUN3)
      FUN3_LB:  FMT_DATA = {{24{byte_sel[7]}}, byte_sel};
      FUN3_LBU: FMT_DATA = {24'd0, byte_sel};
      FUN3_LH:  FMT_DATA = {{16{half_sel[15]}}, half_sel};
      FUN3_LHU: FMT_DATA = {16'd0, half_sel};
      FUN3_LW:  FMT_DATA = LOAD_DATA;
      default:  FMT_DATA = LOAD_DATA;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage: chooses one register write per cycle between the
// MEM3 entry and the multiplier (held or bypassed) and registers it onto the
// register-file write port. x0 is never written.
module writeback_unit
  import writeback_unit_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  writeback_unit_if.slave  bus
);

  mul_hold_t   m_q, m_d;
  wb_type_e    wb_type_q, wb_type_d;
  logic [4:0]  wb_des_q, wb_des_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [31:0] load_fmt;
  logic        p_valid;
  logic        mul_accept;
  logic        mul_ready;

  load_formatter u_load_formatter (
    .FUN3      (bus.FUN3_MEM3),
    .ADDR_LO   (bus.ADDR_LO),
    .LOAD_DATA (bus.LOAD_DATA),
    .FMT_DATA  (load_fmt)
  );

  // The hold buffer being empty is the only readiness condition; it comes
  // straight from a register so the multiplier sees no input-dependent path.
  assign mul_ready  = !m_q.valid;
  assign mul_accept = bus.MUL_VALID && mul_ready;
  assign p_valid    = bus.DATA_CACHE_READY && writes_reg(bus.TYPE_MEM3) &&
                      (bus.RD_MEM3 != 5'd0);

  // Write selection and hold-buffer update.
  always_comb begin
    m_d       = m_q;
    wb_type_d = TYPE_IDLE;
    wb_des_d  = 5'd0;
    wb_data_d = 32'd0;
    if (p_valid) begin
      wb_type_d = wb_type_e'(bus.TYPE_MEM3);
      wb_des_d  = bus.RD_MEM3;
      wb_data_d = (bus.TYPE_MEM3 == TYPE_LOAD) ? load_fmt : bus.ALU_RESULT;
      // The MEM3 entry is younger than anything held: a same-rd held
      // result is stale and is dropped.
      if (m_q.valid && (m_q.rd == bus.RD_MEM3)) begin
        m_d.valid = 1'b0;
      end
      // An offer can only be accepted when M is empty; park it.
      if (mul_accept && (bus.MUL_RD != 5'd0)) begin
        m_d.valid = 1'b1;
        m_d.rd    = bus.MUL_RD;
        m_d.data  = bus.MUL_DATA;
      end
    end else if (m_q.valid) begin
      wb_type_d = TYPE_ALU;
      wb_des_d  = m_q.rd;
      wb_data_d = m_q.data;
      m_d.valid = 1'b0;
    end else if (mul_accept && (bus.MUL_RD != 5'd0)) begin
      // Bypass: an isolated multiply gets ALU latency, M stays empty.
      wb_type_d = TYPE_ALU;
      wb_des_d  = bus.MUL_RD;
      wb_data_d = bus.MUL_DATA;
    end
  end

  // Output register and hold buffer; reset drops any pending multiply.
  always_ff @(posedge CLK) begin
    if (RST) begin
      m_q       <= '0;
      wb_type_q <= TYPE_IDLE;
      wb_des_q  <= 5'd0;
      wb_data_q <= 32'd0;
    end else begin
      m_q       <= m_d;
      wb_type_q <= wb_type_d;
      wb_des_q  <= wb_des_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign bus.MUL_READY    = mul_ready;
  assign bus.TYPE_MEM3_WB = wb_type_q;
  assign bus.WB_DES       = wb_des_q;
  assign bus.WB_DATA      = wb_data_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: a vector table for single-cycle
// behaviour plus hand-written multiplier hold/discard/reset sequences.
module tb_writeback_unit;
  import writeback_unit_pkg::*;

  typedef struct {
    string       name;
    logic [1:0]  ty;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] ld;
    logic        dcr;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdat;
    logic [1:0]  e_ty;
    logic [4:0]  e_des;
    logic [31:0] e_dat;
    logic        e_rdy;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [38:0] exp_q[$];

  writeback_unit_if wbi ();

  writeback_unit dut (
    .CLK (clk),
    .RST (rst),
    .bus (wbi.slave)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t idle_vec(input string name);
    vec_t v;
    v.name = name; v.ty = TYPE_IDLE; v.rd = 5'd0; v.alu = 32'd0;
    v.f3 = 3'd0; v.lo = 2'd0; v.ld = 32'h80FF7F01; v.dcr = 1'b1;
    v.mv = 1'b0; v.mrd = 5'd0; v.mdat = 32'd0;
    v.e_ty = TYPE_IDLE; v.e_des = 5'd0; v.e_dat = 32'd0; v.e_rdy = 1'b1;
    return v;
  endfunction

  function automatic vec_t alu_vec(input string name, input logic [4:0] rd,
                                   input logic [31:0] val);
    vec_t v = idle_vec(name);
    v.ty = TYPE_ALU; v.rd = rd; v.alu = val;
    v.e_ty = TYPE_ALU; v.e_des = rd; v.e_dat = val;
    return v;
  endfunction

  function automatic vec_t load_vec(input string name, input logic [2:0] f3,
                                    input logic [1:0] lo, input logic [31:0] exp_d);
    vec_t v = idle_vec(name);
    v.ty = TYPE_LOAD; v.rd = 5'd10; v.f3 = f3; v.lo = lo;
    v.e_ty = TYPE_LOAD; v.e_des = 5'd10; v.e_dat = exp_d;
    return v;
  endfunction

  // Scoreboard compare against the oldest expectation.
  task automatic check(input string name, input logic e_rdy);
    logic [38:0] exp_w;
    logic [38:0] act_w;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      exp_w = exp_q.pop_front();
      act_w = {wbi.TYPE_MEM3_WB, wbi.WB_DES, wbi.WB_DATA};
      if (act_w !== exp_w) begin
        n_errors++;
        $display("FAIL %s: got type=%0d des=%0d data=%h, want type=%0d des=%0d data=%h",
                 name, act_w[38:37], act_w[36:32], act_w[31:0],
                 exp_w[38:37], exp_w[36:32], exp_w[31:0]);
      end
    end
    n_checks++;
    if (wbi.MUL_READY !== e_rdy) begin
      n_errors++;
      $display("FAIL %s ready: got %b want %b", name, wbi.MUL_READY, e_rdy);
    end
  endtask

  // Driver: present at negedge, sample 1ns after the following rising edge.
  task automatic apply(input vec_t v);
    @(negedge clk);
    wbi.TYPE_MEM3 = v.ty; wbi.RD_MEM3 = v.rd; wbi.ALU_RESULT = v.alu;
    wbi.FUN3_MEM3 = v.f3; wbi.ADDR_LO = v.lo; wbi.LOAD_DATA = v.ld;
    wbi.DATA_CACHE_READY = v.dcr; wbi.MUL_VALID = v.mv;
    wbi.MUL_RD = v.mrd; wbi.MUL_DATA = v.mdat;
    exp_q.push_back({v.e_ty, v.e_des, v.e_dat});
    @(posedge clk);
    #1;
    check(v.name, v.e_rdy);
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    n_checks = 0;
    n_errors = 0;

    tbl.push_back(alu_vec("alu_rd5", 5'd5, 32'h1234));
    tbl.push_back(alu_vec("alu_rd31", 5'd31, 32'hDEADBEEF));
    tbl.push_back(load_vec("lb_off3", FUN3_LB, 2'd3, 32'hFFFFFF80));
    tbl.push_back(load_vec("lbu_off3", FUN3_LBU, 2'd3, 32'h00000080));
    tbl.push_back(load_vec("lb_off0", FUN3_LB, 2'd0, 32'h00000001));
    tbl.push_back(load_vec("lb_off2", FUN3_LB, 2'd2, 32'hFFFFFFFF));
    tbl.push_back(load_vec("lbu_off1", FUN3_LBU, 2'd1, 32'h0000007F));
    tbl.push_back(load_vec("lh_off2", FUN3_LH, 2'd2, 32'hFFFF80FF));
    tbl.push_back(load_vec("lh_off3", FUN3_LH, 2'd3, 32'hFFFF80FF));
    tbl.push_back(load_vec("lh_off0", FUN3_LH, 2'd0, 32'h00007F01));
    tbl.push_back(load_vec("lhu_off0", FUN3_LHU, 2'd0, 32'h00007F01));
    tbl.push_back(load_vec("lhu_off2", FUN3_LHU, 2'd2, 32'h000080FF));
    tbl.push_back(load_vec("lw", FUN3_LW, 2'd0, 32'h80FF7F01));
    tbl.push_back(load_vec("f3_011", 3'b011, 2'd1, 32'h80FF7F01));
    v = alu_vec("store", 5'd4, 32'h55);
    v.ty = TYPE_STORE; v.e_ty = TYPE_IDLE; v.e_des = 5'd0; v.e_dat = 32'd0;
    tbl.push_back(v);
    v = alu_vec("alu_x0", 5'd0, 32'h66);
    v.e_dat = 32'd0; v.e_ty = TYPE_IDLE;
    tbl.push_back(v);
    v = alu_vec("dcr_low", 5'd6, 32'h77);
    v.dcr = 1'b0; v.e_ty = TYPE_IDLE; v.e_des = 5'd0; v.e_dat = 32'd0;
    tbl.push_back(v);
    v = idle_vec("idle");
    v.rd = 5'd8; v.alu = 32'h99;
    tbl.push_back(v);
    v = idle_vec("mul_bypass");
    v.mv = 1'b1; v.mrd = 5'd7; v.mdat = 32'hAB;
    v.e_ty = TYPE_ALU; v.e_des = 5'd7; v.e_dat = 32'hAB;
    tbl.push_back(v);
    v = idle_vec("mul_x0_drop");
    v.mv = 1'b1; v.mrd = 5'd0; v.mdat = 32'hCD;
    tbl.push_back(v);
    v = idle_vec("after_drop");
    tbl.push_back(v);

    // Reset state
    rst = 1'b1;
    v = idle_vec("init");
    wbi.TYPE_MEM3 = v.ty; wbi.RD_MEM3 = v.rd; wbi.ALU_RESULT = v.alu;
    wbi.FUN3_MEM3 = v.f3; wbi.ADDR_LO = v.lo; wbi.LOAD_DATA = v.ld;
    wbi.DATA_CACHE_READY = 1'b0; wbi.MUL_VALID = 1'b0;
    wbi.MUL_RD = 5'd0; wbi.MUL_DATA = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back({TYPE_IDLE, 5'd0, 32'd0});
    check("reset_state", 1'b1);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) apply(tbl[i]);

    // Conflict: offer parked behind an ALU write, then drained.
    v = alu_vec("conf_alu", 5'd3, 32'h33);
    v.mv = 1'b1; v.mrd = 5'd7; v.mdat = 32'hAB; v.e_rdy = 1'b0;
    apply(v);
    v = idle_vec("conf_drain");
    v.e_ty = TYPE_ALU; v.e_des = 5'd7; v.e_dat = 32'hAB;
    apply(v);
    apply(idle_vec("conf_quiet"));

    // M full, P valid, new offer held back until M drains.
    v = alu_vec("stall_a", 5'd3, 32'h30);
    v.mv = 1'b1; v.mrd = 5'd7; v.mdat = 32'h70; v.e_rdy = 1'b0;
    apply(v);
    v = alu_vec("stall_b", 5'd4, 32'h40);
    v.mv = 1'b1; v.mrd = 5'd9; v.mdat = 32'h90; v.e_rdy = 1'b0;
    apply(v);
    v = idle_vec("stall_c");
    v.mv = 1'b1; v.mrd = 5'd9; v.mdat = 32'h90;
    v.e_ty = TYPE_ALU; v.e_des = 5'd7; v.e_dat = 32'h70;
    apply(v);
    v = idle_vec("stall_d");
    v.mv = 1'b1; v.mrd = 5'd9; v.mdat = 32'h90;
    v.e_ty = TYPE_ALU; v.e_des = 5'd9; v.e_dat = 32'h90;
    apply(v);

    // Younger same-rd write discards held result.
    v = alu_vec("disc_a", 5'd3, 32'h31);
    v.mv = 1'b1; v.mrd = 5'd7; v.mdat = 32'h77; v.e_rdy = 1'b0;
    apply(v);
    apply(alu_vec("disc_b", 5'd7, 32'h700));
    apply(idle_vec("disc_c"));

    // Reset with M full drops the held result.
    v = alu_vec("rst_a", 5'd3, 32'h32);
    v.mv = 1'b1; v.mrd = 5'd7; v.mdat = 32'h7E; v.e_rdy = 1'b0;
    apply(v);
    @(negedge clk);
    rst = 1'b1;
    v = idle_vec("rst_pulse");
    apply(v);
    @(negedge clk);
    rst = 1'b0;
    apply(idle_vec("rst_after1"));
    apply(idle_vec("rst_after2"));

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

endmodule
